inst_fetch: RTL and testbench

Instruction fetch unit for the 16-bit accumulator CPU: reads 1- or 2-byte instructions over a byte-wide req/ack memory port, assembles them into the 16-bit instruction word consumed by the decoder, and reports instruction length and fall-through PC. It sits between the external RAM interface and the decoder/execute stage, and is the producer side of the decoder's `inst` input.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/inst_fetch.sv | 156 +++++++++++++++
 tb/tb_inst_fetch.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU: fetch state encoding
// and opcode-length rules used by both fetch and decode.
package cpu_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FETCH_HI = 2'd1;
  localparam logic [1:0] ST_FETCH_LO = 2'd2;
  localparam logic [1:0] ST_VALID    = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    FETCH_HI = ST_FETCH_HI,
    FETCH_LO = ST_FETCH_LO,
    VALID    = ST_VALID
  } fetch_state_e;

  localparam int INST_TWO_BYTE_BIT = 7;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;

  // An opcode with its top bit set carries a one-byte argument.
  function automatic logic [1:0] inst_len_of(input logic [7:0] opcode);
    return opcode[INST_TWO_BYTE_BIT] ? LEN_2 : LEN_1;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: reads 1- or 2-byte instructions over a byte-wide req/ack
// port and presents the assembled 16-bit word to the decoder.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [15:0]       inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [1:0]        inst_len,
  output logic [ADDR_W-1:0] next_pc,
  output logic              busy
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic [1:0]        inst_len_q, inst_len_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic              busy_q, busy_d;
  logic              ack_s;
  logic [1:0]        hi_len_s;

  // An ack only counts while a request is actually outstanding.
  assign ack_s    = mem_ack & mem_req_q;
  assign hi_len_s = inst_len_of(mem_data);

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    inst_len_d   = inst_len_q;
    next_pc_d    = next_pc_q;

    if (flush) begin
      state_d      = IDLE;
      mem_req_d    = 1'b0;
      inst_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_start) begin
            state_d    = FETCH_HI;
            addr_d     = pc;
            mem_req_d  = 1'b1;
            mem_addr_d = pc;
          end else begin
            mem_req_d  = 1'b0;
          end
        end
        FETCH_HI: begin
          if (ack_s) begin
            inst_d[15:8] = mem_data;
            inst_len_d   = hi_len_s;
            if (hi_len_s == LEN_1) begin
              inst_d[7:0]  = 8'h00;
              state_d      = VALID;
              mem_req_d    = 1'b0;
              inst_valid_d = 1'b1;
              next_pc_d    = addr_q + ADDR_W'(LEN_1);
            end else begin
              state_d      = FETCH_LO;
              mem_addr_d   = addr_q + ADDR_W'(LEN_1);
            end
          end else begin
            mem_req_d = 1'b1;
          end
        end
        FETCH_LO: begin
          if (ack_s) begin
            inst_d[7:0]  = mem_data;
            state_d      = VALID;
            mem_req_d    = 1'b0;
            inst_valid_d = 1'b1;
            next_pc_d    = addr_q + ADDR_W'(LEN_2);
          end else begin
            mem_req_d = 1'b1;
          end
        end
        VALID: begin
          if (inst_ready) begin
            inst_valid_d = 1'b0;
            if (fetch_start) begin
              state_d    = FETCH_HI;
              addr_d     = pc;
              mem_req_d  = 1'b1;
              mem_addr_d = pc;
            end else begin
              state_d    = IDLE;
            end
          end else begin
            inst_valid_d = 1'b1;
          end
        end
        default: begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          inst_valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      inst_q       <= 16'h0000;
      inst_valid_q <= 1'b0;
      inst_len_q   <= LEN_1;
      next_pc_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_len_q   <= inst_len_d;
      next_pc_q    <= next_pc_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign inst_len   = inst_len_q;
  assign next_pc    = next_pc_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed fetches against a byte memory model,
// with a monitor that checks every accepted instruction against a queue.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        fetch_start;
  logic [15:0] pc;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  inst_len;
  logic [15:0] next_pc;
  logic        busy;

  logic        auto_ack;
  logic [7:0]  auto_data;
  logic        man_ack;
  logic [7:0]  man_data;
  bit          auto_en = 1'b1;
  int          wait_n = 0;
  int          ack_cnt = 0;
  logic [7:0]  mem [0:65535];

  typedef struct packed {
    logic [15:0] inst;
    logic [1:0]  len;
    logic [15:0] npc;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  assign mem_ack  = auto_ack | man_ack;
  assign mem_data = man_ack ? man_data : auto_data;

  inst_fetch #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc(pc), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_len(inst_len), .next_pc(next_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: acks after wait_n idle cycles per byte.
  initial begin
    int wcnt;
    wcnt = 0;
    auto_ack = 1'b0;
    auto_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (auto_en && mem_req && !rst) begin
        if (wcnt < wait_n) begin
          wcnt++;
          auto_ack = 1'b0;
        end else begin
          wcnt = 0;
          auto_ack = 1'b1;
          auto_data = mem[mem_addr];
          ack_cnt++;
        end
      end else begin
        wcnt = 0;
        auto_ack = 1'b0;
      end
    end
  end

  // Monitor: every accepted instruction must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_inst", {16'h0000, inst}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("inst", {16'h0000, inst}, {16'h0000, e.inst});
          chk("inst_len", {30'd0, inst_len}, {30'd0, e.len});
          chk("next_pc", {16'h0000, next_pc}, {16'h0000, e.npc});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic go(input logic [15:0] a, output int base);
    @(posedge clk);
    #1;
    base = ack_cnt;
    fetch_start = 1'b1;
    pc = a;
    @(posedge clk);
    #1;
    fetch_start = 1'b0;
  endtask

  // Waits (bounded) for inst_valid, checking request address on every request cycle.
  task automatic wait_valid(input logic [15:0] hi, input int exp_cyc, input int exp_acks,
                            input int base, input string tag);
    int got;
    logic [15:0] exp_a;
    got = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, "_req_c1"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_valid_c1"}, {31'd0, inst_valid}, 32'd0);
      end
      if (inst_valid) begin
        got = k;
        break;
      end
      if (mem_req) begin
        exp_a = ((ack_cnt - base - int'(mem_ack)) == 0) ? hi : hi + 16'd1;
        chk({tag, "_addr"}, {16'h0000, mem_addr}, {16'h0000, exp_a});
      end
    end
    chk({tag, "_latency"}, got, exp_cyc);
    chk({tag, "_acks"}, ack_cnt - base, exp_acks);
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_idle_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_idle_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_addr"}, {16'h0000, mem_addr}, 32'd0);
    chk({tag, "_inst"}, {16'h0000, inst}, 32'd0);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_inst_len"}, {30'd0, inst_len}, 32'd1);
    chk({tag, "_next_pc"}, {16'h0000, next_pc}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    fetch_start = 1'b0;
    pc = 16'h0000;
    flush = 1'b0;
    inst_ready = 1'b1;
    man_ack = 1'b0;
    man_data = 8'h00;
    mem[16'h0010] = 8'h01;
    mem[16'h0020] = 8'h88; mem[16'h0021] = 8'h05;
    mem[16'hFFFF] = 8'hC0; mem[16'h0000] = 8'h7F;
    mem[16'h0050] = 8'h02;
    mem[16'h0030] = 8'h90; mem[16'h0031] = 8'h12;
    mem[16'h0040] = 8'h41;
    mem[16'h0070] = 8'h85;
    mem[16'h0080] = 8'h05;

    #2;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1-byte, zero wait
    exp_q.push_back('{inst: 16'h0100, len: 2'd1, npc: 16'h0011});
    go(16'h0010, base);
    wait_valid(16'h0010, 2, 1, base, "one_byte");
    chk_idle("one_byte");

    // 2-byte, 3 wait cycles per byte
    wait_n = 3;
    exp_q.push_back('{inst: 16'h8805, len: 2'd2, npc: 16'h0022});
    go(16'h0020, base);
    wait_valid(16'h0020, 9, 2, base, "two_byte_wait");
    chk_idle("two_byte_wait");

    // Address wrap
    wait_n = 0;
    exp_q.push_back('{inst: 16'hC07F, len: 2'd2, npc: 16'h0001});
    go(16'hFFFF, base);
    wait_valid(16'hFFFF, 3, 2, base, "wrap");
    chk_idle("wrap");

    // Backpressure then back-to-back fetch
    inst_ready = 1'b0;
    exp_q.push_back('{inst: 16'h0200, len: 2'd1, npc: 16'h0051});
    go(16'h0050, base);
    wait_valid(16'h0050, 2, 1, base, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_hold_inst", {16'h0000, inst}, 32'h0000_0200);
      chk("bp_hold_req", {31'd0, mem_req}, 32'd0);
    end
    @(posedge clk);
    #1;
    base = ack_cnt;
    exp_q.push_back('{inst: 16'h9012, len: 2'd2, npc: 16'h0032});
    inst_ready = 1'b1;
    fetch_start = 1'b1;
    pc = 16'h0030;
    @(posedge clk);
    #1;
    fetch_start = 1'b0;
    wait_valid(16'h0030, 3, 2, base, "b2b");
    chk_idle("b2b");

    // Flush in FETCH_LO with coincident ack
    auto_en = 1'b0;
    go(16'h0060, base);
    man_ack = 1'b1;
    man_data = 8'h81;
    @(negedge clk);
    chk("flush_req_hi", {31'd0, mem_req}, 32'd1);
    chk("flush_addr_hi", {16'h0000, mem_addr}, 32'h0000_0060);
    @(posedge clk);
    #1;
    man_data = 8'h33;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_req_lo", {31'd0, mem_req}, 32'd1);
    chk("flush_addr_lo", {16'h0000, mem_addr}, 32'h0000_0061);
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_req_off", {31'd0, mem_req}, 32'd0);
      chk("flush_valid_off", {31'd0, inst_valid}, 32'd0);
      chk("flush_busy_off", {31'd0, busy}, 32'd0);
    end
    auto_en = 1'b1;
    exp_q.push_back('{inst: 16'h4100, len: 2'd1, npc: 16'h0041});
    go(16'h0040, base);
    wait_valid(16'h0040, 2, 1, base, "after_flush");
    chk_idle("after_flush");

    // flush with fetch_start in IDLE drops the start
    @(posedge clk);
    #1;
    flush = 1'b1;
    fetch_start = 1'b1;
    pc = 16'h0040;
    @(posedge clk);
    #1;
    flush = 1'b0;
    fetch_start = 1'b0;
    chk_idle("flush_start");

    // Async reset in FETCH_HI
    wait_n = 5;
    go(16'h0070, base);
    @(negedge clk);
    chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    wait_n = 0;
    exp_q.push_back('{inst: 16'h0500, len: 2'd1, npc: 16'h0081});
    go(16'h0080, base);
    wait_valid(16'h0080, 2, 1, base, "after_rst");
    chk_idle("after_rst");

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
